chacha20_serial_decoder: RTL and testbench
==========================================

Name: chacha20_serial_decoder

Overview:
- Consumer side of the ChaCha20 serial encoder. Takes finished 512-bit keystream blocks and XORs them word-serially against an incoming 32-bit ciphertext stream, emitting plaintext.
- Requests keystream blocks one at a time and tracks the block counter for the core.
- Sits between the keystream generator and the payload datapath. The same block also encrypts, since the XOR is symmetric.

Parameters:
- COUNTER_WIDTH, 32, width of the ChaCha20 block counter.

Ports:
- clock  in  1  system clock, all logic on the rising edge.
- clear_n  in  1  asynchronous active-low reset.
- start  in  1  pulse: begin a message; sampled only in IDLE.
- start_counter  in  COUNTER_WIDTH  initial block counter, loaded on start.
- ks_block  in  512  keystream block; word i = bits [32i+31:32i].
- ks_valid  in  1  keystream block valid.
- ks_ready  out  1  decoder accepts a keystream block.
- ks_counter  out  COUNTER_WIDTH  counter value of the block being requested.
- ct_data  in  32  ciphertext word.
- ct_valid  in  1  ciphertext word valid.
- ct_last  in  1  final word of the message.
- ct_ready  out  1  decoder accepts a ciphertext word.
- pt_data  out  32  plaintext word (registered).
- pt_valid  out  1  plaintext word valid.
- pt_last  out  1  final plaintext word.
- pt_ready  in  1  downstream accepts a plaintext word.
- done  out  1  one-cycle pulse when the last plaintext word is accepted.
- counter_wrap  out  1  sticky: block counter wrapped during the message.

Behaviour:
- Reset (clear_n low, asynchronous):
  - state = IDLE; all outputs 0; word index = 0; ks_counter = 0; counter_wrap = 0.
  - Reset mid-message discards the held block and any pending output word.
- Handshakes:
  - A transfer happens when valid and ready are both high on a rising edge.
  - valid must not depend on ready.
- States:
  - IDLE: ks_ready = 0, ct_ready = 0. On start, load ks_counter = start_counter, clear counter_wrap, go to WAIT_KS.
  - WAIT_KS: ks_ready = 1, ct_ready = 0. On ks transfer: latch ks_block, word index = 0, ks_counter += 1 (modulo 2^COUNTER_WIDTH), go to STREAM.
  - STREAM: ks_ready = 0, ct_ready = !pt_valid || pt_ready.
    - On ct transfer: pt_data <= ct_data XOR keystream word[index]; pt_valid <= 1; pt_last <= ct_last; index += 1.
    - If ct_last, go to FLUSH.
    - Else if index was 15, go to WAIT_KS.
    - Else stay in STREAM.
  - FLUSH: ct_ready = 0, ks_ready = 0. When pt_valid && pt_ready && pt_last: pulse done, go to IDLE.
- Output register:
  - pt_valid clears on pt transfer unless a new ct word is accepted in the same cycle.
  - With pt_ready held high, throughput is 1 word/cycle.
  - Latency is 1 cycle from ct transfer to pt_valid.
- Block boundaries:
  - One bubble cycle minimum per 16 words (the WAIT_KS handshake).
  - No prefetch: the held output word may still be pending while in WAIT_KS.
- Boundary conditions:
  - start outside IDLE is ignored.
  - ct_last on word 15 goes to FLUSH, not WAIT_KS, so no extra block is requested.
  - If ks_counter increments from all-ones to 0, set counter_wrap; it holds until the next start.
  - ks_valid outside WAIT_KS is ignored.
  - ct_valid outside STREAM is not accepted.
  - pt_data, pt_last and pt_valid hold stable while pt_valid && !pt_ready.
  - A single-word message (ct_last on word 0) is legal: one block consumed, done after that word is accepted.

Test Plan:
1. Reset, start with start_counter=1. Feed ks word i = 0x10000000+i and 16 ct words of 0, the last with ct_last. -> pt word i = 0x10000000+i; pt_last only on word 15; done pulses once; ks_counter reads 2 after the block transfer; exactly one ks transfer.
2. RFC 8439 §2.4.2 vector (key 00..1f, nonce 000000000000004a00000000, counter 1): feed the generated keystream and the 114-byte ciphertext as 29 words, zero-padded -> first plaintext word 0x6964614c ("Ladi"), exactly 2 ks transfers, done after word 29.
3. Toggle pt_ready randomly 50% during a 40-word stream -> no word lost or duplicated; pt held stable while stalled; ct_ready low whenever pt_valid && !pt_ready.
4. start_counter=0xFFFFFFFF, 20-word message -> second request shows ks_counter=0; counter_wrap=1 until the next start, which clears it.
5. Drop clear_n mid-block at word 7 -> all outputs 0 immediately; after release, a new start runs test 1 correctly.
6. Pulse start while in STREAM, and pulse ks_valid while in STREAM -> both ignored; pt sequence unchanged versus test 1.

Source files
------------

// File: rtl/chacha20_serial_decoder.sv
// chacha20_serial_decoder: XORs a 32-bit word stream against 512-bit ChaCha20
// keystream blocks. It requests one block per 16 words, tracks the block
// counter for the keystream core and emits a registered plaintext stream.
// The XOR is symmetric, so the same block encrypts as well as decrypts.
module chacha20_serial_decoder #(
  parameter int COUNTER_WIDTH = 32
) (
  input  logic                     clock,
  input  logic                     clear_n,
  input  logic                     start,
  input  logic [COUNTER_WIDTH-1:0] start_counter,
  input  logic [511:0]             ks_block,
  input  logic                     ks_valid,
  output logic                     ks_ready,
  output logic [COUNTER_WIDTH-1:0] ks_counter,
  input  logic [31:0]              ct_data,
  input  logic                     ct_valid,
  input  logic                     ct_last,
  output logic                     ct_ready,
  output logic [31:0]              pt_data,
  output logic                     pt_valid,
  output logic                     pt_last,
  input  logic                     pt_ready,
  output logic                     done,
  output logic                     counter_wrap
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_KS,
    S_STREAM,
    S_FLUSH
  } state_t;

  state_t                   r_state;
  logic [511:0]             r_ks;
  logic [3:0]               r_idx;
  logic [COUNTER_WIDTH-1:0] r_ctr;
  logic                     r_wrap;
  logic [31:0]              r_pt_data;
  logic                     r_pt_valid;
  logic                     r_pt_last;
  logic                     r_done;

  logic                     w_ks_ready;
  logic                     w_ct_ready;
  logic                     w_ks_fire;
  logic                     w_ct_fire;
  logic                     w_pt_fire;
  logic [31:0]              w_ks_word;

  // Ready only depends on state and the output register, never on the
  // upstream valids, so no combinational valid->ready path exists.
  assign w_ks_ready = (r_state == S_WAIT_KS);
  assign w_ct_ready = (r_state == S_STREAM) && (!r_pt_valid || pt_ready);
  assign w_ks_fire  = w_ks_ready && ks_valid;
  assign w_ct_fire  = w_ct_ready && ct_valid;
  assign w_pt_fire  = r_pt_valid && pt_ready;
  assign w_ks_word  = r_ks[{r_idx, 5'd0} +: 32];

  assign ks_ready     = w_ks_ready;
  assign ct_ready     = w_ct_ready;
  assign ks_counter   = r_ctr;
  assign counter_wrap = r_wrap;
  assign pt_data      = r_pt_data;
  assign pt_valid     = r_pt_valid;
  assign pt_last      = r_pt_last;
  assign done         = r_done;

  // Control FSM, keystream holding register, counter and output register.
  // NOTE: every register here uses <= so all updates see pre-edge values;
  // blocking assignments would make the result depend on statement order.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      r_state    <= S_IDLE;
      // NOTE: the held block is a plain register, not a RAM, so it is reset
      // to guarantee a discarded message leaves no key material behind.
      r_ks       <= '0;
      r_idx      <= '0;
      r_ctr      <= '0;
      r_wrap     <= 1'b0;
      r_pt_data  <= '0;
      r_pt_valid <= 1'b0;
      r_pt_last  <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;

      // Output register: drains on a downstream transfer, refilled by a new
      // word accepted in the same cycle (the later assignment wins).
      if (w_pt_fire) begin
        r_pt_valid <= 1'b0;
        r_pt_last  <= 1'b0;
      end
      if (w_ct_fire) begin
        r_pt_data  <= ct_data ^ w_ks_word;
        r_pt_valid <= 1'b1;
        r_pt_last  <= ct_last;
        r_idx      <= r_idx + 4'd1;
      end

      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_ctr   <= start_counter;
            r_wrap  <= 1'b0;
            r_state <= S_WAIT_KS;
          end
        end
        S_WAIT_KS: begin
          if (w_ks_fire) begin
            r_ks    <= ks_block;
            r_idx   <= '0;
            r_ctr   <= r_ctr + COUNTER_WIDTH'(1);
            if (&r_ctr) r_wrap <= 1'b1;
            r_state <= S_STREAM;
          end
        end
        S_STREAM: begin
          if (w_ct_fire) begin
            if (ct_last)            r_state <= S_FLUSH;
            else if (r_idx == 4'd15) r_state <= S_WAIT_KS;
          end
        end
        S_FLUSH: begin
          if (w_pt_fire && r_pt_last) begin
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_chacha20_serial_decoder.sv
// Testbench for chacha20_serial_decoder: drivers for the keystream and
// ciphertext channels, a random pt_ready source, and a negedge monitor that
// checks every plaintext word and block request against a scoreboard.
module tb_chacha20_serial_decoder;

  localparam int BUDGET = 500;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } pt_t;

  logic         clock;
  logic         clear_n;
  logic         start;
  logic [31:0]  start_counter;
  logic [511:0] ks_block;
  logic         ks_valid;
  logic         ks_ready;
  logic [31:0]  ks_counter;
  logic [31:0]  ct_data;
  logic         ct_valid;
  logic         ct_last;
  logic         ct_ready;
  logic [31:0]  pt_data;
  logic         pt_valid;
  logic         pt_last;
  logic         pt_ready;
  logic         done;
  logic         counter_wrap;

  chacha20_serial_decoder #(.COUNTER_WIDTH(32)) dut (
    .clock(clock), .clear_n(clear_n), .start(start),
    .start_counter(start_counter), .ks_block(ks_block),
    .ks_valid(ks_valid), .ks_ready(ks_ready), .ks_counter(ks_counter),
    .ct_data(ct_data), .ct_valid(ct_valid), .ct_last(ct_last),
    .ct_ready(ct_ready), .pt_data(pt_data), .pt_valid(pt_valid),
    .pt_last(pt_last), .pt_ready(pt_ready), .done(done),
    .counter_wrap(counter_wrap)
  );

  int n_cmp = 0;
  int n_fail = 0;

  // Stimulus data for the current message and scoreboard queues.
  logic [31:0]  g_ct[$];
  logic [511:0] g_ks[$];
  pt_t          exp_q[$];
  logic [31:0]  exp_ctr_q[$];

  bit          stall_mode = 0;
  bit          gaps = 0;
  bit          mon_en = 0;
  bit          first_pending = 0;
  logic [31:0] first_pt;
  int          done_cnt = 0;
  int          ks_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial clock = 0;
  always #5 clock = ~clock;

  // Downstream ready: always high, or a coin toss per cycle when stalling.
  initial begin
    pt_ready = 1;
    forever begin
      @(posedge clock); #1;
      pt_ready = stall_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: observes handshakes at negedge, when every signal is settled.
  bit          held, prev_last;
  logic [31:0] held_data;
  logic        held_last;
  pt_t         e;
  always @(negedge clock) begin
    if (!clear_n || !mon_en) begin
      held      = 0;
      prev_last = 0;
    end else begin
      if (held) begin
        check("stall_valid", pt_valid, 1);
        check("stall_data", pt_data, held_data);
        check("stall_last", pt_last, held_last);
      end
      if (pt_valid && !pt_ready) check("ct_ready_backpressure", ct_ready, 0);
      if (done || prev_last) check("done_pulse", done, prev_last);
      if (done) done_cnt++;
      if (pt_valid && pt_ready) begin
        if (exp_q.size() == 0) check("pt_extra_word", pt_valid, 0);
        else begin
          e = exp_q.pop_front();
          check("pt_data", pt_data, e.data);
          check("pt_last", pt_last, e.last);
          if (first_pending) begin
            first_pt      = pt_data;
            first_pending = 0;
          end
        end
      end
      if (ks_valid && ks_ready) begin
        ks_cnt++;
        if (exp_ctr_q.size() == 0) check("ks_extra_xfer", ks_ready, 0);
        else check("ks_counter_req", ks_counter, exp_ctr_q.pop_front());
      end
      held      = pt_valid && !pt_ready;
      held_data = pt_data;
      held_last = pt_last;
      prev_last = pt_valid && pt_ready && pt_last;
    end
  end

  // ChaCha20 reference: quarter round on a packed 16-word state.
  function automatic logic [511:0] qr(input logic [511:0] v, input int a, input int b,
                                      input int c, input int d);
    logic [31:0] xa, xb, xc, xd;
    xa = v[32*a +: 32]; xb = v[32*b +: 32]; xc = v[32*c +: 32]; xd = v[32*d +: 32];
    xa += xb; xd ^= xa; xd = {xd[15:0], xd[31:16]};
    xc += xd; xb ^= xc; xb = {xb[19:0], xb[31:20]};
    xa += xb; xd ^= xa; xd = {xd[23:0], xd[31:24]};
    xc += xd; xb ^= xc; xb = {xb[24:0], xb[31:25]};
    v[32*a +: 32] = xa; v[32*b +: 32] = xb; v[32*c +: 32] = xc; v[32*d +: 32] = xd;
    return v;
  endfunction

  // Block function with key bytes 00..1f and nonce 000000000000004a00000000.
  function automatic logic [511:0] chacha_block(input logic [31:0] ctr);
    logic [511:0] s, x;
    s[31:0] = 32'h61707865; s[63:32] = 32'h3320646e;
    s[95:64] = 32'h79622d32; s[127:96] = 32'h6b206574;
    for (int k = 0; k < 8; k++)
      s[128 + 32*k +: 32] = {8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)};
    s[415:384] = ctr; s[447:416] = 32'h0; s[479:448] = 32'h4a000000; s[511:480] = 32'h0;
    x = s;
    for (int r = 0; r < 10; r++) begin
      x = qr(x, 0, 4, 8, 12); x = qr(x, 1, 5, 9, 13);
      x = qr(x, 2, 6, 10, 14); x = qr(x, 3, 7, 11, 15);
      x = qr(x, 0, 5, 10, 15); x = qr(x, 1, 6, 11, 12);
      x = qr(x, 2, 7, 8, 13); x = qr(x, 3, 4, 9, 14);
    end
    for (int i = 0; i < 16; i++) x[32*i +: 32] = x[32*i +: 32] + s[32*i +: 32];
    return x;
  endfunction

  task automatic prep_test1();
    logic [511:0] blk;
    g_ct.delete(); g_ks.delete();
    for (int i = 0; i < 16; i++) begin
      blk[32*i +: 32] = 32'h10000000 + 32'(i);
      g_ct.push_back(32'h0);
    end
    g_ks.push_back(blk);
  endtask

  task automatic prep_rand(input int n);
    logic [511:0] blk;
    g_ct.delete(); g_ks.delete();
    for (int b = 0; b < (n + 15) / 16; b++) begin
      for (int i = 0; i < 16; i++) blk[32*i +: 32] = $urandom;
      g_ks.push_back(blk);
    end
    for (int i = 0; i < n; i++) g_ct.push_back($urandom);
  endtask

  task automatic prep_rfc();
    string        msg;
    logic [31:0]  w;
    logic [511:0] blk;
    int           idx;
    msg = "Ladies and Gentlemen of the class of '99: If I could offer you only one tip for the future, sunscreen would be it.";
    g_ct.delete(); g_ks.delete();
    g_ks.push_back(chacha_block(32'd1));
    g_ks.push_back(chacha_block(32'd2));
    for (int j = 0; j < 29; j++) begin
      for (int b = 0; b < 4; b++) begin
        idx = 4*j + b;
        w[8*b +: 8] = (idx < msg.len()) ? msg[idx] : 8'h00;
      end
      blk = g_ks[j / 16];
      g_ct.push_back(w ^ blk[32*(j % 16) +: 32]);
    end
  endtask

  // Keystream driver; optionally holds a junk block valid during STREAM.
  task automatic feed_ks(input int nb, input bit inject);
    int t;
    for (int b = 0; b < nb; b++) begin
      if (gaps) begin
        ks_valid = 0;
        repeat ($urandom_range(0, 2)) begin @(posedge clock); #1; end
      end
      ks_valid = 1;
      ks_block = g_ks[b];
      t = 0;
      @(negedge clock);
      while (!ks_ready && t < BUDGET) begin @(negedge clock); t++; end
      check("ks_ready_wait", ks_ready, 1);
      @(posedge clock); #1;
    end
    if (inject) begin
      ks_valid = 1;
      ks_block = {16{$urandom}};
      repeat (10) begin @(posedge clock); #1; end
    end
    ks_valid = 0;
  endtask

  // Ciphertext driver; optionally pulses start mid-stream.
  task automatic feed_ct(input int n, input bit inject);
    int t;
    for (int i = 0; i < n; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        ct_valid = 0;
        @(posedge clock); #1;
      end
      ct_valid = 1;
      ct_data  = g_ct[i];
      ct_last  = (i == n - 1);
      t = 0;
      @(negedge clock);
      while (!ct_ready && t < BUDGET) begin @(negedge clock); t++; end
      check("ct_ready_wait", ct_ready, 1);
      @(posedge clock); #1;
      if (inject && i == 4) begin
        ct_valid      = 0;
        start         = 1;
        start_counter = $urandom;
        @(posedge clock); #1;
        start = 0;
      end
    end
    ct_valid = 0;
    ct_last  = 0;
  endtask

  // One message: fill the scoreboard from the model, run, check the outcome.
  task automatic run_msg(input logic [31:0] sc, input int n, input bit inject);
    int           nb, d0, k0, t;
    logic [511:0] blk;
    logic [31:0]  end_ctr;
    bit           wrap_exp;
    nb       = (n + 15) / 16;
    end_ctr  = sc + 32'(nb);
    wrap_exp = (64'(sc) + 64'(nb)) > 64'hFFFF_FFFF;
    for (int i = 0; i < n; i++) begin
      blk = g_ks[i / 16];
      exp_q.push_back(pt_t'{data: g_ct[i] ^ blk[32*(i % 16) +: 32], last: (i == n - 1)});
    end
    for (int b = 0; b < nb; b++) exp_ctr_q.push_back(sc + 32'(b));
    d0 = done_cnt;
    k0 = ks_cnt;
    first_pending = 1;
    start = 1;
    start_counter = sc;
    @(posedge clock); #1;
    start = 0;
    check("start_counter_load", ks_counter, sc);
    check("wrap_cleared_on_start", counter_wrap, 0);
    check("ks_ready_after_start", ks_ready, 1);
    fork
      feed_ks(nb, inject);
      feed_ct(n, inject);
    join
    t = 0;
    while (done_cnt == d0 && t < BUDGET) begin @(negedge clock); t++; end
    check("done_count", done_cnt - d0, 1);
    check("ks_transfers", ks_cnt - k0, nb);
    check("pt_queue_drained", exp_q.size(), 0);
    check("end_counter", ks_counter, end_ctr);
    check("counter_wrap", counter_wrap, wrap_exp);
    repeat (3) @(negedge clock);
    check("done_single_pulse", done_cnt - d0, 1);
    check("wrap_sticky", counter_wrap, wrap_exp);
    @(posedge clock); #1;
  endtask

  initial begin
    int acc, t;
    clear_n = 0; start = 0; start_counter = 0; ks_block = 0; ks_valid = 0;
    ct_data = 0; ct_valid = 0; ct_last = 0;
    #12;
    check("reset_ks_ready", ks_ready, 0);
    check("reset_ct_ready", ct_ready, 0);
    check("reset_pt_valid", pt_valid, 0);
    check("reset_ks_counter", ks_counter, 0);
    check("reset_done", done, 0);
    clear_n = 1;
    mon_en  = 1;
    @(posedge clock); #1;

    // Single block with counting keystream, ct_last on word 15.
    prep_test1();
    run_msg(32'd1, 16, 0);

    // RFC 8439 sunscreen vector over two blocks.
    prep_rfc();
    run_msg(32'd1, 29, 0);
    check("rfc_first_word", first_pt, 32'h6964614c);

    // 40 words with random back-pressure and upstream gaps.
    stall_mode = 1; gaps = 1;
    prep_rand(40);
    run_msg($urandom, 40, 0);
    stall_mode = 0; gaps = 0;

    // Counter wrap from all-ones.
    prep_rand(20);
    run_msg(32'hFFFF_FFFF, 20, 0);

    // Reset in the middle of a block after word 7.
    mon_en = 0;
    prep_rand(16);
    start = 1; start_counter = 32'd5;
    @(posedge clock); #1;
    start = 0;
    ks_valid = 1; ks_block = g_ks[0];
    ct_valid = 1; ct_data = $urandom; ct_last = 0;
    acc = 0; t = 0;
    while (acc < 7 && t < BUDGET) begin
      @(negedge clock); t++;
      if (ct_valid && ct_ready) acc++;
    end
    check("reset_test_words", acc, 7);
    @(posedge clock); #2;
    ct_valid = 0; ks_valid = 0;
    check("pre_reset_pt_valid", pt_valid, 1);
    clear_n = 0;
    #1;
    check("mid_reset_ks_ready", ks_ready, 0);
    check("mid_reset_ks_counter", ks_counter, 0);
    check("mid_reset_ct_ready", ct_ready, 0);
    check("mid_reset_pt_data", pt_data, 0);
    check("mid_reset_pt_valid", pt_valid, 0);
    check("mid_reset_pt_last", pt_last, 0);
    check("mid_reset_done", done, 0);
    check("mid_reset_wrap", counter_wrap, 0);
    #2 clear_n = 1;
    @(posedge clock); #1;
    mon_en = 1;
    prep_test1();
    run_msg(32'd1, 16, 0);

    // Stray start and ks_valid while streaming.
    prep_test1();
    run_msg(32'd1, 16, 1);

    // Random messages, starting with a single-word one.
    for (int m = 0; m < 6; m++) begin
      int n;
      n = (m == 0) ? 1 : int'($urandom_range(1, 40));
      stall_mode = 1'($urandom_range(0, 1));
      gaps       = 1'($urandom_range(0, 1));
      prep_rand(n);
      run_msg($urandom, n, 1'($urandom_range(0, 1)));
    end
    stall_mode = 0; gaps = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    n_fail++;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
